scramble64b66b_tx: RTL
======================

Name: scramble64b66b_tx

Overview:
- Transmit-side 64b/66b scrambler for the low-latency PCS/PMA path.
- Accepts 66-bit blocks (2-bit sync header plus 64-bit payload) from the PCS encoder through a valid/ready handshake.
- Scrambles the payload with the self-synchronous polynomial x^58+x^39+1. The header is not scrambled.
- Drives an external-sequence-mode transceiver gearbox. It generates the gearbox sequence counter and inserts scrambled idle blocks when no data is offered.

Parameters:
- SEQ_MAX, 32: terminal value of the gearbox sequence counter. When txseq_o equals this value, the gearbox ignores the block.
- IDLE_HEAD, 2'b10: sync header of an inserted idle block.
- IDLE_DATA, 64'h000000000000001E: payload of an inserted idle block, before scrambling.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- data_i  input  64  unscrambled payload; bit 0 is transmitted first.
- head_i  input  2  sync header.
- vld_i  input  1  data_i/head_i valid.
- rdy_o  output  1  block can accept input this cycle.
- data_o  output  64  scrambled payload to the gearbox.
- head_o  output  2  sync header to the gearbox.
- txseq_o  output  6  gearbox sequence value, aligned with data_o.
- idle_o  output  1  the current data_o is an inserted idle block.

Behaviour:
- Reset:
  - scrambler state s[57:0] = all ones.
  - data_o = 0, head_o = 2'b00, txseq_o = 0, idle_o = 0.
  - Internal sequence counter = 0.
- Reset is asynchronous. Deassertion mid-stream restarts from the reset values. No partial block is emitted.
- Scrambler, applied to bits i = 0..63 in order:
  - out[i] = d[i] ^ s[0] ^ s[19].
  - Then s = {out[i], s[57:1]}.
  - The shift-in uses the scrambled bit.
  - All 64 steps resolve within one cycle.
- Sequence counter:
  - Increments every clock from 0 to SEQ_MAX, then wraps to 0.
  - txseq_o is registered and always equals the value of the block presented on data_o/head_o.
- rdy_o:
  - rdy_o = 0 when the internal counter equals SEQ_MAX-1, because the next output slot is a pause slot. Otherwise rdy_o = 1.
  - rdy_o is derived only from registers. It does not depend on vld_i.
  - Accept = vld_i & rdy_o.
- Per-cycle outputs, registered, latency 1:
  - Pause slot (next txseq = SEQ_MAX): data_o, head_o and s hold their values; idle_o = 0. The incoming block is not consumed.
  - Accept: data_o = scrambled data_i, head_o = head_i, s advances, idle_o = 0.
  - No vld_i on a non-pause slot: data_o = scrambled IDLE_DATA, head_o = IDLE_HEAD, s advances, idle_o = 1.
- vld_i held high while rdy_o = 0: the block stays pending and is accepted in the next cycle. The source must keep data_i/head_i stable.
- Header values 2'b00 and 2'b11 are passed through unchanged. Header checking is done upstream.
- Round-trip requirement: data_o fed to the team's 64b/66b descrambler (reset state all ones) reproduces the accepted payloads and headers exactly, with the pause slots removed.

Optional Feature:
- Macro: TX_IDLE_CNT_EN.
- Defined:
  - Adds output idle_cnt_o[31:0] and input idle_cnt_clr_i.
  - The counter increments once per inserted idle block and saturates at 32'hFFFFFFFF.
  - idle_cnt_clr_i synchronously clears the counter to 0 and takes priority over an increment in the same cycle.
  - The counter resets to 0 on rst_n.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then vld_i = 0 for 100 cycles:
  - every non-pause cycle has idle_o = 1 and head_o = 2'b10.
  - descrambled data_o = 64'h1E.
  - txseq_o cycles 0..32.
- Reset, then one block (data_i = 0, head_i = 2'b01):
  - data_o bits 0..38 = 0 and bit 39 = 1; matches the bit-serial reference model.
  - head_o = 2'b01 one cycle after accept.
- Continuous vld_i with an incrementing payload for 200 cycles:
  - rdy_o is low exactly when the counter = 31.
  - at txseq_o = 32, outputs hold the previous block.
  - loopback through the descrambler recovers every payload in order, with none lost or duplicated.
- vld_i asserted on the cycle rdy_o = 0: the block is accepted on the next cycle and appears with txseq_o = 0.
- Assert rst_n low mid-stream:
  - all outputs return to reset values asynchronously.
  - after release, the first scrambled block matches the output for scrambler state all ones.
- TX_IDLE_CNT_EN:
  - 5 idle slots give idle_cnt_o = 5.
  - preload near saturation via long idle: the counter holds at 32'hFFFFFFFF.
  - clear and increment in the same cycle give 0.

Source files
------------

// File: rtl/scramble64b66b_tx.sv
// ---------------------------------------------------------------------------
// scramble64b66b_tx
//   Transmit-side 64b/66b scrambler feeding an external-sequence-mode
//   transceiver gearbox. The 64-bit payload is scrambled with the
//   self-synchronous polynomial x^58 + x^39 + 1. The 2-bit sync header
//   passes through unscrambled. The block generates the gearbox sequence
//   counter. When no data is offered on a usable slot, it inserts a
//   scrambled idle block.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   data_i[63:0]   unscrambled payload; bit 0 is transmitted first
//   head_i[1:0]    sync header
//   vld_i          data_i/head_i valid
//   rdy_o          block can be accepted this cycle (register-derived)
//   data_o[63:0]   scrambled payload to the gearbox
//   head_o[1:0]    sync header to the gearbox
//   txseq_o[5:0]   gearbox sequence value of the block on data_o/head_o
//   idle_o         data_o carries an inserted idle block
//
// Optional build macro TX_IDLE_CNT_EN adds:
//   idle_cnt_clr_i   synchronous clear of the idle counter (wins over increment)
//   idle_cnt_o[31:0] saturating count of inserted idle blocks
// ---------------------------------------------------------------------------
module scramble64b66b_tx #(
    parameter int          SEQ_MAX   = 32,
    parameter logic [1:0]  IDLE_HEAD = 2'b10,
    parameter logic [63:0] IDLE_DATA = 64'h000000000000001E
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] data_i,
    input  logic [1:0]  head_i,
    input  logic        vld_i,
    output logic        rdy_o,
    output logic [63:0] data_o,
    output logic [1:0]  head_o,
    output logic [5:0]  txseq_o,
`ifdef TX_IDLE_CNT_EN
    input  logic        idle_cnt_clr_i,
    output logic [31:0] idle_cnt_o,
`endif
    output logic        idle_o
);

    localparam logic [5:0] SEQ_LAST  = 6'(SEQ_MAX);
    localparam logic [5:0] SEQ_PAUSE = 6'(SEQ_MAX - 1);

    // Scramble 64 bits serially. Each scrambled bit shifts back into the
    // state, so the result is the whole bit-serial recurrence unrolled into
    // one cycle. Returns {next_state, scrambled_payload}.
    function automatic logic [121:0] scramble(input logic [63:0] d,
                                              input logic [57:0] s_in);
        logic [57:0] s;
        logic [63:0] o;
        s = s_in;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ s[0] ^ s[19];
            s    = {o[i], s[57:1]};
        end
        return {s, o};
    endfunction

    logic [57:0] scr_s;
    logic [57:0] scr_s_nxt;
    logic [63:0] scr_out;
    logic [63:0] blk_data;
    logic [1:0]  blk_head;
    logic        pause;
    logic        accept;
    logic [5:0]  seq_nxt;

    // txseq_o itself is the sequence counter. The slot after SEQ_MAX-1 is
    // the pause slot, which the gearbox discards.
    assign pause   = (txseq_o == SEQ_PAUSE);
    assign rdy_o   = ~pause;
    assign accept  = vld_i & rdy_o;
    assign seq_nxt = (txseq_o == SEQ_LAST) ? 6'd0 : txseq_o + 6'd1;

    assign blk_data = accept ? data_i : IDLE_DATA;
    assign blk_head = accept ? head_i : IDLE_HEAD;

    assign {scr_s_nxt, scr_out} = scramble(blk_data, scr_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_s   <= '1;
            data_o  <= '0;
            head_o  <= 2'b00;
            txseq_o <= '0;
            idle_o  <= 1'b0;
        end else begin
            txseq_o <= seq_nxt;
            if (pause) begin
                // Data, header and scrambler state hold across the pause slot.
                idle_o <= 1'b0;
            end else begin
                data_o <= scr_out;
                head_o <= blk_head;
                scr_s  <= scr_s_nxt;
                idle_o <= ~accept;
            end
        end
    end

`ifdef TX_IDLE_CNT_EN
    logic [31:0] idle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt_q <= '0;
        else if (idle_cnt_clr_i)
            idle_cnt_q <= '0;
        else if (!pause && !accept && idle_cnt_q != '1)
            idle_cnt_q <= idle_cnt_q + 32'd1;
    end

    assign idle_cnt_o = idle_cnt_q;
`endif

endmodule
